sgd_x_writeback_engine: RTL and testbench

Parametrised successor to the model (x) write-back path. On each epoch trigger it reads the updated model rows from the distributed x memory and serialises every engine's bank word into BEAT_W beats. It issues burst-split host-memory write commands and streams the beats out with a valid/ready handshake. It adds generic engine/bank/beat widths, burst splitting, an overwrite-or-append epoch address mode and true back-pressure. Single clock domain; sits between the SGD engines' x memories and the host DMA write port.

---
 rtl/sgd_wb_pkg.sv | 50 +++++
 rtl/sgd_wb_beat_fifo.sv | 57 +++++
 rtl/sgd_x_writeback_engine.sv | 221 ++++++++++++++++++++++
 tb/tb_sgd_x_writeback_engine.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgd_wb_pkg.sv
// Shared definitions for the model (x) write-back engine.
// Contents:
//   wb_state_t  - top-level FSM states
//   calc_bpw    - beats per engine bank word (BANK_BITS / BEAT_W)
//   calc_rows   - x-memory rows needed to cover a model dimension (minimum 1)
//   calc_beats  - total beats for a number of rows
//   min_beats   - smaller of two beat counts
//   byte_len    - byte length of a number of beats
package sgd_wb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TRIG,
        CMD,
        STREAM,
        END
    } wb_state_t;

    function automatic int unsigned calc_bpw(input int unsigned bank_bits,
                                             input int unsigned beat_w);
        return bank_bits / beat_w;
    endfunction

    // A zero dimension still writes one row, so the host always sees a burst.
    function automatic logic [31:0] calc_rows(input logic [31:0] dimension,
                                              input int unsigned fpr);
        logic [32:0] num;
        if (dimension == 32'd0) begin
            return 32'd1;
        end
        num = {1'b0, dimension} + {1'b0, fpr} - 33'd1;
        return 32'(num / {1'b0, fpr});
    endfunction

    function automatic logic [31:0] calc_beats(input logic [31:0] rows,
                                               input int unsigned beats_per_row);
        return rows * beats_per_row;
    endfunction

    function automatic logic [31:0] min_beats(input logic [31:0] a,
                                              input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [63:0] byte_len(input logic [31:0] beats,
                                             input int unsigned beat_w);
        return {32'd0, beats} * {32'd0, beat_w / 8};
    endfunction

endpackage

// File: rtl/sgd_wb_beat_fifo.sv
// Single-clock first-word-fall-through beat FIFO.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data  - write request; ignored while full (even if a pop happens)
//   pop              - read request; ignored while empty
//   head             - current head word (valid while !empty)
//   full, empty      - status flags
//   count            - number of stored words
// FIFO_DEPTH must be a power of two and at least 2.
module sgd_wb_beat_fifo #(
    parameter int BEAT_W     = 512,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [BEAT_W-1:0]             push_data,
    input  logic                          pop,
    output logic [BEAT_W-1:0]             head,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [BEAT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sgd_x_writeback_engine.sv
// Model (x) write-back engine.
// On each wb_en rising edge (while armed) it issues burst-split host write
// commands covering one epoch, then reads the x-memory rows one at a time,
// slices every engine's bank word into BEAT_W beats and streams them out.
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   started, wb_en              - job armed level, write-back trigger (rising edge)
//   addr_model, dimension,
//   num_epochs                  - job description
//   wb_done, um_done            - epoch done pulse, sticky all-epochs done
//   x_mem_rd_*                  - x-memory row read port (data RD_LAT after strobe)
//   cmd_*                       - host write command channel (valid/ready)
//   data_out/valid/ready        - beat stream (valid/ready)
//   epoch_cnt, beat_cnt         - epochs completed, beats accepted since reset
module sgd_x_writeback_engine
    import sgd_wb_pkg::*;
#(
    parameter int ENGINE_NUM      = 8,
    parameter int BANK_BITS       = 2048,
    parameter int BEAT_W          = 512,
    parameter int X_ADDR_W        = 9,
    parameter int RD_LAT          = 11,
    parameter int FIFO_DEPTH      = 64,
    parameter int MAX_BURST_BEATS = 64,
    parameter int APPEND_MODE     = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            started,
    input  logic [63:0]                     addr_model,
    input  logic [31:0]                     dimension,
    input  logic [31:0]                     num_epochs,
    input  logic                            wb_en,
    output logic                            wb_done,
    output logic                            um_done,
    output logic [X_ADDR_W-1:0]             x_mem_rd_addr,
    output logic                            x_mem_rd_en,
    input  logic [ENGINE_NUM*BANK_BITS-1:0] x_mem_rd_data,
    output logic                            cmd_valid,
    input  logic                            cmd_ready,
    output logic [63:0]                     cmd_addr,
    output logic [31:0]                     cmd_len,
    output logic [BEAT_W-1:0]               data_out,
    output logic                            data_valid,
    input  logic                            data_ready,
    output logic [31:0]                     epoch_cnt,
    output logic [31:0]                     beat_cnt
);

    localparam int unsigned BPW         = calc_bpw(BANK_BITS, BEAT_W);
    localparam int unsigned SLICES      = ENGINE_NUM * BPW;
    localparam int unsigned FPR         = ENGINE_NUM * BANK_BITS / 32;
    localparam int          ROW_W       = ENGINE_NUM * BANK_BITS;
    localparam int          CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] MAX_BEATS   = MAX_BURST_BEATS;
    localparam logic [63:0] BURST_BYTES = byte_len(MAX_BEATS, BEAT_W);

    wb_state_t state;
    logic        wb_en_d1, wb_en_d2;
    logic [31:0] rows_reg, cmd_left, stream_left;

    // Combinational job geometry, latched on the trigger.
    logic [31:0] rows_calc, beats_calc, first_burst, next_burst;
    logic [63:0] epoch_bytes_calc, base_calc;

    always_comb begin
        rows_calc        = calc_rows(dimension, FPR);
        beats_calc       = calc_beats(rows_calc, SLICES);
        epoch_bytes_calc = byte_len(beats_calc, BEAT_W);
        base_calc        = addr_model;
        if (APPEND_MODE != 0) begin
            base_calc = addr_model + {32'd0, epoch_cnt} * epoch_bytes_calc;
        end
        first_burst = min_beats(beats_calc, MAX_BEATS);
        next_burst  = min_beats(cmd_left, MAX_BEATS);
    end

    // Row fetch / serialiser state.
    logic [RD_LAT-1:0] rd_pipe;
    logic [31:0]       rows_issued, slice_idx;
    logic              buf_full;
    logic [ROW_W-1:0]  row_buf;
    logic              issue, capture, fifo_push, push_last;

    // FIFO side.
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [BEAT_W-1:0] fifo_head;
    logic              beat_fire;

    assign data_valid = (fifo_count != '0);
    assign data_out   = fifo_empty ? '0 : fifo_head;
    assign beat_fire  = data_valid & data_ready;

    // One row in flight at a time: the buffer must be free and nothing pending.
    assign issue     = (state == STREAM) && !buf_full && !x_mem_rd_en &&
                       (rd_pipe == '0) && (rows_issued != rows_reg);
    assign capture   = rd_pipe[RD_LAT-1];
    assign fifo_push = buf_full && !fifo_full;
    assign push_last = fifo_push && (slice_idx == SLICES - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wb_en_d1    <= 1'b0;
            wb_en_d2    <= 1'b0;
            rows_reg    <= '0;
            cmd_left    <= '0;
            stream_left <= '0;
            cmd_valid   <= 1'b0;
            cmd_addr    <= '0;
            cmd_len     <= '0;
            wb_done     <= 1'b0;
            um_done     <= 1'b0;
            epoch_cnt   <= '0;
            beat_cnt    <= '0;
        end else begin
            wb_en_d1 <= wb_en;
            wb_en_d2 <= wb_en_d1;
            wb_done  <= 1'b0;
            if (beat_fire) beat_cnt <= beat_cnt + 32'd1;

            unique case (state)
                IDLE: begin
                    if (started) state <= WAIT_TRIG;
                end
                WAIT_TRIG: begin
                    if (epoch_cnt == num_epochs) begin
                        state <= END;
                    end else if (wb_en_d1 && !wb_en_d2) begin
                        rows_reg    <= rows_calc;
                        stream_left <= beats_calc;
                        cmd_left    <= beats_calc - first_burst;
                        cmd_addr    <= base_calc;
                        cmd_len     <= 32'(byte_len(first_burst, BEAT_W));
                        cmd_valid   <= 1'b1;
                        state       <= CMD;
                    end
                end
                CMD: begin
                    // cmd_left counts beats not yet covered by an issued command.
                    if (cmd_ready) begin
                        if (cmd_left == 32'd0) begin
                            cmd_valid <= 1'b0;
                            state     <= STREAM;
                        end else begin
                            cmd_addr <= cmd_addr + BURST_BYTES;
                            cmd_len  <= 32'(byte_len(next_burst, BEAT_W));
                            cmd_left <= cmd_left - next_burst;
                        end
                    end
                end
                STREAM: begin
                    if (beat_fire) begin
                        stream_left <= stream_left - 32'd1;
                        if (stream_left == 32'd1) begin
                            wb_done   <= 1'b1;
                            epoch_cnt <= epoch_cnt + 32'd1;
                            state     <= WAIT_TRIG;
                        end
                    end
                end
                END: begin
                    um_done <= 1'b1;
                    if (!started) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_mem_rd_en   <= 1'b0;
            x_mem_rd_addr <= '0;
            rd_pipe       <= '0;
            rows_issued   <= '0;
            buf_full      <= 1'b0;
            slice_idx     <= '0;
        end else begin
            x_mem_rd_en <= issue;
            rd_pipe     <= (rd_pipe << 1) | RD_LAT'(x_mem_rd_en);
            // Address advances once the strobe has been presented; wraps after the last row.
            if (x_mem_rd_en) begin
                if (32'(x_mem_rd_addr) == rows_reg - 32'd1) x_mem_rd_addr <= '0;
                else                                        x_mem_rd_addr <= x_mem_rd_addr + 1'b1;
            end
            if (state != STREAM) rows_issued <= '0;
            else if (issue)      rows_issued <= rows_issued + 32'd1;
            if (capture) begin
                buf_full  <= 1'b1;
                slice_idx <= '0;
            end else if (fifo_push) begin
                slice_idx <= slice_idx + 32'd1;
                if (push_last) buf_full <= 1'b0;
            end
        end
    end

    // Row buffer shifts down one beat per push, so the next slice is always at the bottom.
    always_ff @(posedge clk) begin
        if (capture)        row_buf <= x_mem_rd_data;
        else if (fifo_push) row_buf <= row_buf >> BEAT_W;
    end

    sgd_wb_beat_fifo #(
        .BEAT_W    (BEAT_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_data(row_buf[BEAT_W-1:0]),
        .pop      (data_ready),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_sgd_x_writeback_engine.sv
module tb_sgd_x_writeback_engine;

    localparam int ENGINE_NUM      = 2;
    localparam int BANK_BITS       = 1024;
    localparam int BEAT_W          = 512;
    localparam int X_ADDR_W        = 9;
    localparam int RD_LAT          = 3;
    localparam int FIFO_DEPTH      = 4;
    localparam int MAX_BURST_BEATS = 4;
    localparam int APPEND_MODE     = 1;
    localparam int ROW_W           = ENGINE_NUM * BANK_BITS;
    localparam int FPR             = ROW_W / 32;
    localparam int BEATS_PER_ROW   = ROW_W / BEAT_W;
    localparam int BEAT_BYTES      = BEAT_W / 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                started = 1'b0;
    logic [63:0]         addr_model = '0;
    logic [31:0]         dimension = '0;
    logic [31:0]         num_epochs = '0;
    logic                wb_en = 1'b0;
    logic                wb_done, um_done;
    logic [X_ADDR_W-1:0] x_mem_rd_addr;
    logic                x_mem_rd_en;
    logic [ROW_W-1:0]    x_mem_rd_data = '0;
    logic                cmd_valid;
    logic                cmd_ready = 1'b1;
    logic [63:0]         cmd_addr;
    logic [31:0]         cmd_len;
    logic [BEAT_W-1:0]   data_out;
    logic                data_valid;
    logic                data_ready = 1'b1;
    logic [31:0]         epoch_cnt, beat_cnt;

    sgd_x_writeback_engine #(
        .ENGINE_NUM(ENGINE_NUM), .BANK_BITS(BANK_BITS), .BEAT_W(BEAT_W),
        .X_ADDR_W(X_ADDR_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH),
        .MAX_BURST_BEATS(MAX_BURST_BEATS), .APPEND_MODE(APPEND_MODE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .started(started), .addr_model(addr_model),
        .dimension(dimension), .num_epochs(num_epochs), .wb_en(wb_en),
        .wb_done(wb_done), .um_done(um_done), .x_mem_rd_addr(x_mem_rd_addr),
        .x_mem_rd_en(x_mem_rd_en), .x_mem_rd_data(x_mem_rd_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .data_out(data_out), .data_valid(data_valid),
        .data_ready(data_ready), .epoch_cnt(epoch_cnt), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [ROW_W-1:0] rand_row();
        logic [ROW_W-1:0] r;
        for (int i = 0; i < ROW_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- x-memory model ----------------
    logic [ROW_W-1:0] mem_rows [16];
    int cyc = 0;
    int rd_due_q[$];
    int rd_addr_q[$];

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            rd_due_q.delete();
            rd_addr_q.delete();
        end else if (x_mem_rd_en) begin
            rd_due_q.push_back(cyc + RD_LAT - 1);
            rd_addr_q.push_back(int'(x_mem_rd_addr));
        end
        #1;
        if (rd_due_q.size() > 0 && rd_due_q[0] == cyc) begin
            x_mem_rd_data = mem_rows[rd_addr_q[0] % 16];
            void'(rd_due_q.pop_front());
            void'(rd_addr_q.pop_front());
        end else begin
            x_mem_rd_data = rand_row();
        end
    end

    // ---------------- ready drivers ----------------
    int rdy_mode = 0;   // 0: always ready, 1: 1-0-0-1 pattern, 2: random
    int rdy_phase = 0;
    int cmd_stall = 0;

    always @(posedge clk) begin
        #1;
        rdy_phase++;
        case (rdy_mode)
            1:       data_ready = ((rdy_phase % 4) == 0) || ((rdy_phase % 4) == 3);
            2:       data_ready = 1'($urandom_range(0, 1));
            default: data_ready = 1'b1;
        endcase
        if (cmd_stall > 0) begin
            cmd_ready = 1'b0;
            cmd_stall--;
        end else begin
            cmd_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    logic [BEAT_W-1:0] exp_beat_q[$];
    logic [63:0]       exp_caddr_q[$];
    logic [31:0]       exp_clen_q[$];
    int                wb_done_cnt = 0;
    logic              cmd_hold = 1'b0;
    logic [95:0]       cmd_held;
    logic              dat_hold = 1'b0;
    logic [BEAT_W-1:0] dat_held;

    always @(negedge clk) begin
        if (!rst_n) begin
            cmd_hold = 1'b0;
            dat_hold = 1'b0;
        end else begin
            if (cmd_hold) chk("cmd_stable", {cmd_valid, cmd_addr, cmd_len}, {1'b1, cmd_held});
            cmd_hold = 1'b0;
            if (cmd_valid) begin
                if (cmd_ready) begin
                    if (exp_caddr_q.size() == 0) begin
                        chk("cmd_unexpected", 1'b1, 1'b0);
                    end else begin
                        chk("cmd_addr", cmd_addr, exp_caddr_q.pop_front());
                        chk("cmd_len", cmd_len, exp_clen_q.pop_front());
                    end
                end else begin
                    cmd_hold = 1'b1;
                    cmd_held = {cmd_addr, cmd_len};
                end
            end
            if (dat_hold) chk("data_stable", {data_valid, data_out}, {1'b1, dat_held});
            dat_hold = 1'b0;
            if (data_valid) begin
                chk("beat_before_cmds", 32'(exp_caddr_q.size()), 0);
                if (data_ready) begin
                    if (exp_beat_q.size() == 0) chk("beat_unexpected", 1'b1, 1'b0);
                    else                        chk("beat_data", data_out, exp_beat_q.pop_front());
                end else begin
                    dat_hold = 1'b1;
                    dat_held = data_out;
                end
            end
            if (wb_done) wb_done_cnt++;
        end
    end

    // ---------------- tasks ----------------
    task automatic apply_reset();
        logic any_out;
        @(posedge clk);
        #2;
        rst_n   = 1'b0;
        started = 1'b0;
        wb_en   = 1'b0;
        #1;
        any_out = cmd_valid | data_valid | wb_done | um_done | x_mem_rd_en |
                  (|cmd_addr) | (|cmd_len) | (|data_out) | (|epoch_cnt) |
                  (|beat_cnt) | (|x_mem_rd_addr);
        chk("reset_outputs", any_out, 1'b0);
        exp_beat_q.delete();
        exp_caddr_q.delete();
        exp_clen_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n       = 1'b1;
        wb_done_cnt = 0;
        cmd_stall   = 0;
    endtask

    task automatic arm();
        @(posedge clk);
        #1 started = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    // Model the epoch from the job description, then pulse wb_en.
    task automatic start_epoch(input int ep, output int beats);
        int rows, rem, k, n;
        logic [ROW_W-1:0] row;
        logic [63:0] base;
        rows  = (dimension == 0) ? 1 : int'((dimension + FPR - 1) / FPR);
        beats = rows * BEATS_PER_ROW;
        base  = addr_model + 64'(ep) * 64'(beats * BEAT_BYTES);
        for (int r = 0; r < rows; r++) begin
            mem_rows[r] = rand_row();
            row = mem_rows[r];
            for (int s = 0; s < BEATS_PER_ROW; s++) exp_beat_q.push_back(row[s*BEAT_W +: BEAT_W]);
        end
        rem = beats;
        k   = 0;
        while (rem > 0) begin
            n = (rem < MAX_BURST_BEATS) ? rem : MAX_BURST_BEATS;
            exp_caddr_q.push_back(base + 64'(k * MAX_BURST_BEATS * BEAT_BYTES));
            exp_clen_q.push_back(32'(n * BEAT_BYTES));
            rem -= n;
            k++;
        end
        @(posedge clk);
        #1 wb_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 wb_en = 1'b0;
    endtask

    task automatic wait_epoch_done(input int ep);
        int t = 0;
        while (!wb_done && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("wb_done_ep%0d", ep), wb_done, 1'b1);
        @(negedge clk);
        chk("beats_left", 32'(exp_beat_q.size()), 0);
        chk("cmds_left", 32'(exp_caddr_q.size()), 0);
    endtask

    task automatic finish_job(input int exp_ep, input int exp_beats);
        int t = 0;
        while (!um_done && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("um_done", um_done, 1'b1);
        chk("epoch_cnt", epoch_cnt, 32'(exp_ep));
        chk("beat_cnt", beat_cnt, 32'(exp_beats));
        chk("wb_done_cnt", 32'(wb_done_cnt), 32'(exp_ep));
        $display("job: epochs=%0d beats=%0d checks=%0d", epoch_cnt, beat_cnt, n_checks);
    endtask

    function automatic logic [63:0] rand_base();
        return {$urandom, $urandom} & ~64'h3F;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int b, total, t;

        // 1: two rows, two bursts, one epoch
        apply_reset();
        addr_model = rand_base(); dimension = 100; num_epochs = 1; rdy_mode = 0;
        arm();
        start_epoch(0, b);
        wait_epoch_done(0);
        finish_job(1, 8);

        // 2: exactly one row
        apply_reset();
        addr_model = rand_base(); dimension = 64; num_epochs = 1; rdy_mode = 0;
        arm();
        start_epoch(0, b);
        wait_epoch_done(0);
        finish_job(1, 4);

        // 3: data back-pressure 1-0-0-1
        apply_reset();
        addr_model = rand_base(); dimension = 100; num_epochs = 1; rdy_mode = 1;
        arm();
        start_epoch(0, b);
        wait_epoch_done(0);
        finish_job(1, 8);

        // 4: append mode, three epochs
        apply_reset();
        addr_model = rand_base(); dimension = 100; num_epochs = 3; rdy_mode = 0;
        arm();
        for (int e = 0; e < 3; e++) begin
            start_epoch(e, b);
            wait_epoch_done(e);
        end
        finish_job(3, 24);

        // 5: command channel stalled
        apply_reset();
        addr_model = rand_base(); dimension = 100; num_epochs = 1; rdy_mode = 0;
        arm();
        cmd_stall = 40;
        start_epoch(0, b);
        wait_epoch_done(0);
        finish_job(1, 8);

        // 6: reset in the middle of streaming, then a clean epoch
        apply_reset();
        addr_model = rand_base(); dimension = 100; num_epochs = 1; rdy_mode = 0;
        arm();
        start_epoch(0, b);
        t = 0;
        while (beat_cnt < 3 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("mid_stream_reached", 1'(beat_cnt >= 3), 1'b1);
        apply_reset();
        arm();
        start_epoch(0, b);
        wait_epoch_done(0);
        finish_job(1, 8);

        // 7: randomized dimensions and random back-pressure
        apply_reset();
        addr_model = rand_base(); num_epochs = 3; rdy_mode = 2;
        arm();
        total = 0;
        for (int e = 0; e < 3; e++) begin
            dimension = (e == 0) ? 32'd0 : 32'($urandom_range(1, 448));
            start_epoch(e, b);
            total += b;
            wait_epoch_done(e);
        end
        finish_job(3, total);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
